mm_result_drain: RTL
====================

# mm_result_drain

Downstream stage of the matrix-multiply controller. Captures each 2n-bit result strobe with its row/column indices into a small FIFO, then serialises every entry onto an n-bit valid/ready output bus as four beats. Tracks completion: counts drained results and raises `done` once the multiplier has signalled finish and every buffered result has left.

## Interface
- `N`, 20, index width and output beat width; result width is 2N
- `DEPTH`, 4, FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_write`  in  1  result strobe, one cycle per result, active high
- `in_row`  in  N  row index of result
- `in_col`  in  N  column index of result
- `in_data`  in  2N  signed result value
- `in_finish`  in  1  multiplier completion pulse/level
- `in_stall`  out  1  FIFO full (advisory to upstream)
- `out_valid`  out  1  beat available
- `out_ready`  in  1  sink accepts beat
- `out_data`  out  N  beat payload
- `out_beat`  out  2  beat index 0..3
- `out_last`  out  1  final beat of final result
- `count`  out  N  results fully transmitted
- `done`  out  1  sticky completion
- `overflow`  out  1  sticky: a strobe was dropped

## Operation
- FIFO entry = {row, col, data}, 4N bits.
- Push: `in_write`=1 and (not full, or a pop occurs same cycle) → entry written. Push while full with no same-cycle pop → entry dropped, `overflow` set sticky.
- Beats per entry: 0 = row, 1 = col, 2 = data[2N-1:N], 3 = data[N-1:0]. Beat advances on `out_valid & out_ready`; pop on beat-3 handshake, beat counter wraps to 0.
- `out_data`/`out_beat` driven from FIFO head and beat counter; `out_data`=0 when `out_valid`=0.
- `finish_seen` latched on `in_finish`=1 (sticky until reset); strobe coincident with finish is still captured.
- `out_last` = beat 3 & `finish_seen` & FIFO holds exactly one entry & no push this cycle.
- `count` increments on each pop; wraps at 2^N.
- FSM: IDLE (FIFO empty, `out_valid`=0) → SEND when FIFO non-empty; SEND → IDLE on final pop with no pending entries and not `finish_seen`; SEND/IDLE → DONE when `finish_seen` & FIFO empty & beat counter 0. DONE: `done`=1, further `in_write` ignored (not flagged), leaves only via reset.
- `in_stall` = FIFO full (registered occupancy == DEPTH).

## Timing
- Reset (async assert, sync deassert expected upstream): FIFO empty, beat 0, state IDLE, all outputs 0.
- Strobe at edge k → `out_valid`=1 with beat 0 from cycle after k if FIFO was empty.
- Full throughput with `out_ready` held 1: one beat/cycle, one result per 4 cycles; sustained input faster than 1 per 4 cycles fills FIFO.
- `out_valid` never deasserts mid-entry; payload stable while `out_ready`=0.
- `done` rises the cycle after the final beat-3 handshake (or the cycle after `finish_seen` sets if FIFO already empty).
- Reset asserted mid-operation: FIFO contents discarded, all outputs 0 immediately.

## Structure
- Package `mm_pkg`: state enum (IDLE/SEND/DONE), beat enum (BEAT_ROW/COL/HI/LO), default `N`, `DEPTH`.
- Sub-module `mm_result_fifo`: parameterised synchronous FIFO (width 4N, depth `DEPTH`) with push/pop/full/empty/occupancy; top holds FSM, beat counter, flags, counter.

## Test plan
- Reset: drive `reset`=0 → all outputs 0, `out_valid`=0; release → still idle.
- Single result row=1, col=2, data=-3, `out_ready`=1 → beats 0x00001, 0x00002, 0xFFFFF, 0xFFFFD on consecutive cycles, `count`=1.
- Backpressure: drop `out_ready` for 5 cycles at beat 1 → `out_data`=0x00002, `out_beat`=1 held; resumes with beat 2.
- Overflow: 5 back-to-back strobes, `out_ready`=0 → `in_stall`=1 after 4th, 5th dropped, `overflow`=1; drain yields exactly 4 entries, `count`=4.
- Finish coincident with 3rd strobe, `out_ready`=1 → `out_last` only on 3rd entry beat 3, `done`=1 next cycle, `count`=3; later strobes ignored.
- Async reset during beat 2 → outputs 0 same cycle, FIFO empty after release, no stale beats.

Source files
------------

// File: rtl/mm_pkg.sv
// mm_pkg
//   Shared types and default sizes for the matrix-multiply result drain.
//   - state_t : drain controller state (IDLE / SEND / DONE)
//   - beat_t  : which field of a buffered result is on the output bus
//   - MM_N, MM_DEPTH : default index/beat width and FIFO depth
package mm_pkg;

   localparam int MM_N     = 20;
   localparam int MM_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      BEAT_ROW = 2'd0,
      BEAT_COL = 2'd1,
      BEAT_HI  = 2'd2,
      BEAT_LO  = 2'd3
   } beat_t;

endpackage

// File: rtl/mm_result_drain_if.sv
// mm_result_drain_if
//   Result strobe input bus plus the n-bit valid/ready beat output bus.
//   slave  : view used by mm_result_drain (consumes strobes, produces beats)
//   master : view used by the upstream multiplier / downstream sink model
//   Signals: in_write, in_row, in_col, in_data (signed 2N), in_finish,
//            in_stall, out_valid, out_ready, out_data, out_beat, out_last
interface mm_result_drain_if #(
   parameter int N = 20
);
   logic                  in_write;
   logic [N-1:0]          in_row;
   logic [N-1:0]          in_col;
   logic signed [2*N-1:0] in_data;
   logic                  in_finish;
   logic                  in_stall;
   logic                  out_valid;
   logic                  out_ready;
   logic [N-1:0]          out_data;
   logic [1:0]            out_beat;
   logic                  out_last;

   modport slave (
      input  in_write, in_row, in_col, in_data, in_finish, out_ready,
      output in_stall, out_valid, out_data, out_beat, out_last
   );

   modport master (
      output in_write, in_row, in_col, in_data, in_finish, out_ready,
      input  in_stall, out_valid, out_data, out_beat, out_last
   );
endinterface

// File: rtl/mm_result_fifo.sv
// mm_result_fifo
//   Synchronous FIFO, W bits wide, DEPTH entries (power of two).
//   Ports: clk, reset (async active-low), push/wdata, pop/rdata (head, show-ahead),
//          full, empty, occ (registered occupancy 0..DEPTH).
//   Caller guarantees no push when full without a same-cycle pop, and no pop when empty.
module mm_result_fifo #(
   parameter int W     = 80,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   occ
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   occ <= occ + OCC_ONE;
            2'b01:   occ <= occ - OCC_ONE;
            default: occ <= occ;
         endcase
      end
   end

   // Storage is data only; emptiness is carried by occ, so no reset here.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (occ == OCC_FULL);
   assign empty = (occ == '0);
endmodule

// File: rtl/mm_result_drain.sv
// mm_result_drain
//   Buffers {row, col, data} result strobes in a FIFO and serialises each entry
//   as four N-bit beats (row, col, data hi, data lo) on a valid/ready bus.
//   Ports: clk, reset (async active-low), bus (mm_result_drain_if.slave),
//          count  - results fully transmitted (wraps at 2^N)
//          done   - sticky: finish seen and every buffered result drained
//          overflow - sticky: a strobe arrived while full and was dropped
module mm_result_drain
   import mm_pkg::*;
#(
   parameter int N     = MM_N,
   parameter int DEPTH = MM_DEPTH
) (
   input  logic                clk,
   input  logic                reset,
   mm_result_drain_if.slave    bus,
   output logic [N-1:0]        count,
   output logic                done,
   output logic                overflow
);
   localparam int OW = $clog2(DEPTH) + 1;

   state_t         state, state_nxt;
   beat_t          beat;
   logic           finish_seen;
   logic [4*N-1:0] head;
   logic           full, empty, one_left;
   logic [OW-1:0]  occ;
   logic           write_en, hs, pop, push;

   // Strobes are ignored once DONE; they are neither stored nor flagged.
   assign write_en = bus.in_write && (state != DONE);
   assign hs       = bus.out_valid && bus.out_ready;
   assign pop      = hs && (beat == BEAT_LO);
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push     = write_en && (!full || pop);
   assign one_left = (occ == OW'(1));

   mm_result_fifo #(.W(4*N), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata ({bus.in_row, bus.in_col, bus.in_data}),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .occ   (occ)
   );

   assign bus.out_valid = !empty;
   assign bus.out_beat  = beat;
   assign bus.in_stall  = full;
   assign bus.out_last  = (beat == BEAT_LO) && finish_seen && one_left && !push;
   assign done          = (state == DONE);

   always_comb begin
      bus.out_data = '0;
      if (bus.out_valid) begin
         case (beat)
            BEAT_ROW: bus.out_data = head[4*N-1 -: N];
            BEAT_COL: bus.out_data = head[3*N-1 -: N];
            BEAT_HI:  bus.out_data = head[2*N-1 -: N];
            default:  bus.out_data = head[N-1:0];
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         beat        <= BEAT_ROW;
         finish_seen <= 1'b0;
         count       <= '0;
         overflow    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (bus.in_finish) finish_seen <= 1'b1;
         if (hs) beat <= beat_t'(beat + 2'd1);
         if (pop) count <= count + N'(1);
         if (write_en && full && !pop) overflow <= 1'b1;
      end
   end

   // SEND holds exactly while the FIFO has entries; DONE is terminal.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (push)
               state_nxt = SEND;
            else if (finish_seen && empty && (beat == BEAT_ROW))
               state_nxt = DONE;
         end
         SEND: begin
            if (pop && one_left && !push)
               state_nxt = finish_seen ? DONE : IDLE;
         end
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end
endmodule
